nibble_serial_addsub_32: RTL and testbench
==========================================

// Module: nibble_serial_addsub_32
// PURPOSE
//  Area-reduced sequential 32-bit adder/subtractor; sibling alternative to the 32-bit CLA datapath.
//  Loads two operands, then processes one 4-bit slice per clock, LSB nibble first.
//  Carry between slices is held in a register; the slice uses the same complement-on-Cin rule as the 4-bit RCA.
//  Results feed the same result/flag consumers as the CLA: S, Cout, plus optional V/Z.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of 4 and >= 8
//  NIB    WIDTH/4  derived slice count; not overridable
// PORTS
//  clk    in   1      rising-edge clock (single clock domain)
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  A      in   WIDTH  operand A, captured when start is accepted
//  B      in   WIDTH  operand B, captured when start is accepted
//  Sub    in   1      0 = A+B; 1 = A-B (~B plus carry-in 1); captured with operands
//  busy   out  1      high while in RUN
//  done   out  1      high for exactly one cycle when S/Cout are final
//  S      out  WIDTH  result; holds its value until the next accepted start
//  Cout   out  1      final carry-out; on subtract, 1 = no borrow (A >= B unsigned)
//  V      out  1      signed overflow (OVF_FLAGS_EN only; otherwise constant 0)
//  Z      out  1      S == 0 (OVF_FLAGS_EN only; otherwise constant 0)
// BEHAVIOUR
//  Reset: state=IDLE; S=0, Cout=0, busy=0, done=0, V=0, Z=0; counter and carry cleared.
//  Reset overrides everything, including mid-RUN: abort, outputs cleared on the next edge, no done pulse.
//  FSM IDLE -> RUN -> DONE:
//   - IDLE: start=1 => capture A, Bx = Sub ? ~B : B, carry = Sub, cnt = 0; go to RUN.
//   - RUN, each edge: {c, s4} = A[4cnt+:4] + Bx[4cnt+:4] + carry.
//     Write s4 into S[4cnt+:4]; carry <= c; cnt++.
//     When cnt == NIB-1: Cout <= c, go to DONE.
//   - DONE: done=1 for this one cycle.
//     start=1 => accept new operands exactly as in IDLE (back-to-back, no idle cycle).
//     Otherwise go to IDLE.
//  Latency: start accepted at edge k; state enters DONE at edge k+NIB (k+8 for WIDTH=32).
//   done is sampled high at edge k+NIB+1. Throughput: one op per NIB+1 cycles.
//  start in RUN is ignored; there is no queueing. A/B/Sub changes after capture have no effect.
//  S update on accepted start: S clears to 0 on the capture edge; partial nibbles are visible during RUN.
//   S is valid only while done=1 and after it, until the next start.
//  busy = (state==RUN); done = (state==DONE). Both are decoded from registered state: glitch-free, no comb path from inputs.
//  Arithmetic: modulo 2^WIDTH; no saturation. Cout/V/Z are registered at the DONE transition.
//  cnt is $clog2(NIB) bits; it never wraps inside an operation (reset to 0 on each capture).
// CONFIGURATION
//  OVF_FLAGS_EN defined:
//   - V <= (A[W-1] == Bx[W-1]) && (S[W-1] != A[W-1]), evaluated with the final MSB nibble.
//   - Z <= (S == 0) with the final nibble included.
//   - Both update on the edge entering DONE; both clear on an accepted start.
//  OVF_FLAGS_EN undefined: V and Z are tied to 0; no flag logic is synthesized. Ports still exist.
// TESTING
//  1. A=5, B=3, Sub=0, start for one cycle -> busy for 8 cycles; done one cycle; S=8, Cout=0, V=0, Z=0.
//  2. A=0xFFFFFFFF, B=1, Sub=0 -> S=0, Cout=1, Z=1, V=0.
//  3. A=3, B=5, Sub=1 -> S=0xFFFFFFFE, Cout=0 (borrow), V=0. Also A=5, B=3, Sub=1 -> S=2, Cout=1.
//  4. A=0x7FFFFFFF, B=1, Sub=0 -> S=0x80000000, V=1. Also A=0x80000000, B=1, Sub=1 -> S=0x7FFFFFFF, V=1.
//  5. start held high during RUN with new operands -> ignored; first result is unchanged.
//     Then rst in RUN cycle 4 -> next edge: busy=0, S=0, no done pulse.
//  6. start asserted in the DONE cycle -> RUN begins next edge; two results complete 9 cycles apart.
//     With the macro undefined, V=Z=0 throughout.

Source files
------------

// File: rtl/nibble_serial_addsub_32.sv
// Nibble-serial WIDTH-bit adder/subtractor: one 4-bit slice per clock, LSB nibble first.
// Optional V/Z flags are built only when OVF_FLAGS_EN is defined; otherwise both are tied to 0.
module nibble_serial_addsub_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CNTW = $clog2(NIB);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNTW-1:0]  cnt_q;

    logic [CNTW+1:0]  base;
    logic [4:0]       slice_sum;
    logic [WIDTH-1:0] s_upd;
    logic             last;
    logic             accept;

    always_comb begin
        base      = {cnt_q, 2'b00};
        slice_sum = 5'(a_q[base +: 4]) + 5'(bx_q[base +: 4]) + 5'(carry_q);
        s_upd     = s_q;
        s_upd[base +: 4] = slice_sum[3:0];
        last      = (cnt_q == CNTW'(NIB - 1));
        accept    = start && ((state_q == StIdle) || (state_q == StDone));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Subtract is A + ~B + 1; the +1 rides in as the first slice carry.
                        a_q     <= A;
                        bx_q    <= Sub ? ~B : B;
                        carry_q <= Sub;
                        cnt_q   <= '0;
                        s_q     <= '0;
                        cout_q  <= 1'b0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    s_q     <= s_upd;
                    carry_q <= slice_sum[4];
                    if (last) begin
                        cout_q  <= slice_sum[4];
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign S    = s_q;
    assign Cout = cout_q;

`ifdef OVF_FLAGS_EN
    logic v_q;
    logic z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (accept) begin
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if ((state_q == StRun) && last) begin
            // slice_sum[3] is the final result MSB on the last slice.
            v_q <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
            z_q <= (s_upd == '0);
        end
    end

    assign V = v_q;
    assign Z = z_q;
`else
    assign V = 1'b0;
    assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_32.sv
// Self-checking bench for nibble_serial_addsub_32: directed, random, start-in-run,
// reset-mid-run and back-to-back scenarios against a plain-arithmetic reference model.
module tb_nibble_serial_addsub_32;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Sub;
    logic        busy;
    logic        done;
    logic [31:0] S;
    logic        Cout;
    logic        V;
    logic        Z;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        v;
        logic        z;
    } exp_t;

    nibble_serial_addsub_32 #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Sub  (Sub),
        .busy (busy),
        .done (done),
        .S    (S),
        .Cout (Cout),
        .V    (V),
        .Z    (Z)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [32:0] wide;
        longint      sa;
        longint      sb;
        longint      r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sub) begin
            wide   = {1'b0, a} + {1'b0, b};
            e.s    = wide[31:0];
            e.cout = wide[32];
            r      = sa + sb;
        end else begin
            e.s    = a - b;
            e.cout = (a >= b);
            r      = sa - sb;
        end
`ifdef OVF_FLAGS_EN
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.z = (e.s == 32'd0);
`else
        e.v = (r > 64'sd2147483647) && 1'b0;
        e.z = 1'b0;
`endif
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub);
        A     = a;
        B     = b;
        Sub   = sub;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges with busy high; returns at the first negedge with busy low.
    task automatic wait_done(output int nb);
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h1234_5678;
        Sub   = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, S, Cout, V, Z} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b S=%h Cout=%b V=%b Z=%b, expected all 0",
                     busy, done, S, Cout, V, Z);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [6] = '{32'd5, 32'hFFFF_FFFF, 32'd3, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [6] = '{32'd3, 32'd1, 32'd5, 32'd3, 32'd1, 32'd1};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_t        e;
        int          nb;
        for (int i = 0; i < 6; i++) begin
            e = model(ta[i], tb[i], ts[i]);
            launch(ta[i], tb[i], ts[i]);
            vectors++;
            if (S !== 32'd0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_capture: S=%h busy=%b, expected S=0 busy=1", i, S, busy);
            end
            wait_done(nb);
            vectors++;
            if (done !== 1'b1 || nb != 8) begin
                miscompares++;
                $display("FAIL dir%0d_latency: done=%b busy_cycles=%0d, expected 1 8", i, done, nb);
            end
            vectors++;
            if ({S, Cout, V, Z} !== {e.s, e.cout, e.v, e.z}) begin
                miscompares++;
                $display("FAIL dir%0d_result: S=%h Cout=%b V=%b Z=%b, expected S=%h Cout=%b V=%b Z=%b",
                         i, S, Cout, V, Z, e.s, e.cout, e.v, e.z);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || S !== e.s) begin
                miscompares++;
                $display("FAIL dir%0d_pulse: done=%b busy=%b S=%h, expected 0 0 %h",
                         i, done, busy, S, e.s);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        exp_t        e;
        int          nb;
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = (i % 6 == 5) ? a : $urandom;
            sub = (i % 6 == 5) ? 1'b1 : 1'($urandom_range(0, 1));
            e   = model(a, b, sub);
            launch(a, b, sub);
            A = $urandom;
            B = $urandom;
            wait_done(nb);
            vectors++;
            if (done !== 1'b1 || nb != 8 ||
                {S, Cout, V, Z} !== {e.s, e.cout, e.v, e.z}) begin
                miscompares++;
                $display("FAIL rand%0d: done=%b cyc=%0d S=%h Cout=%b V=%b Z=%b, expected 1 8 %h %b %b %b (A=%h B=%h Sub=%b)",
                         i, done, nb, S, Cout, V, Z, e.s, e.cout, e.v, e.z, a, b, sub);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_in_run;
        exp_t e;
        int   nb;
        e     = model(32'h1357_9BDF, 32'h0246_8ACE, 1'b1);
        A     = 32'h1357_9BDF;
        B     = 32'h0246_8ACE;
        Sub   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A   = $urandom;
            B   = $urandom;
            Sub = ~Sub;
        end
        start = 1'b0;
        wait_done(nb);
        vectors++;
        if (done !== 1'b1 || nb + 3 != 8) begin
            miscompares++;
            $display("FAIL start_in_run_latency: done=%b busy_cycles=%0d, expected 1 8", done, nb + 3);
        end
        vectors++;
        if ({S, Cout, V, Z} !== {e.s, e.cout, e.v, e.z}) begin
            miscompares++;
            $display("FAIL start_in_run_result: S=%h Cout=%b V=%b Z=%b, expected S=%h Cout=%b V=%b Z=%b",
                     S, Cout, V, Z, e.s, e.cout, e.v, e.z);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_run_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        launch(32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (S !== 32'h0000_0333 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_nibbles: S=%h busy=%b, expected 00000333 1", S, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, S, Cout, V, Z} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b S=%h Cout=%b V=%b Z=%b, expected all 0",
                     busy, done, S, Cout, V, Z);
        end
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: busy/done cycles=%0d, expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a2;
        logic [31:0] b2;
        exp_t        e1;
        exp_t        e2;
        int          nb;
        a2 = $urandom;
        b2 = $urandom;
        e1 = model(32'h8000_0000, 32'h8000_0000, 1'b0);
        e2 = model(a2, b2, 1'b1);
        launch(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(nb);
        vectors++;
        if (done !== 1'b1 || {S, Cout, V, Z} !== {e1.s, e1.cout, e1.v, e1.z}) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b S=%h Cout=%b V=%b Z=%b, expected 1 %h %b %b %b",
                     done, S, Cout, V, Z, e1.s, e1.cout, e1.v, e1.z);
        end
        launch(a2, b2, 1'b1);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || S !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b S=%h, expected 1 0 00000000", busy, done, S);
        end
        wait_done(nb);
        vectors++;
        if (done !== 1'b1 || nb + 1 != 9) begin
            miscompares++;
            $display("FAIL b2b_spacing: done=%b gap=%0d, expected 1 9", done, nb + 1);
        end
        vectors++;
        if ({S, Cout, V, Z} !== {e2.s, e2.cout, e2.v, e2.z}) begin
            miscompares++;
            $display("FAIL b2b_second: S=%h Cout=%b V=%b Z=%b, expected S=%h Cout=%b V=%b Z=%b",
                     S, Cout, V, Z, e2.s, e2.cout, e2.v, e2.z);
        end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Sub   = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_start_in_run;
        test_reset_mid_run;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
